// File: rtl/control_pos_memoria_rr_if.sv
// Bus between the memory-bus window mux controller and the requesting windows.
// master: request side; slave: the round-robin position controller.
interface control_pos_memoria_rr_if #(
    parameter int unsigned N_VENTANAS = 4,
    parameter int unsigned ANCHO_POS  = 2
);
    logic [N_VENTANAS-1:0] solicitud;
    logic [ANCHO_POS-1:0]  posicion;
    logic                  habilitar_cambio;
    logic [N_VENTANAS-1:0] concesion;
    logic                  ocupado;

    modport master (
        output solicitud,
        input  posicion, habilitar_cambio, concesion, ocupado
    );

    modport slave (
        input  solicitud,
        output posicion, habilitar_cambio, concesion, ocupado
    );
endinterface

// File: rtl/control_pos_memoria_rr.sv
// Round-robin arbiter that selects which window drives the shared memory bus.
// The controller holds a one-cycle mux switch (CAMBIO), then a bounded grant (ACCESO).
module control_pos_memoria_rr #(
    parameter int unsigned N_VENTANAS    = 4,
    parameter int unsigned ANCHO_POS     = 2,
    parameter int unsigned CICLOS_ACCESO = 4
) (
    input logic                    clk,
    input logic                    reset,
    control_pos_memoria_rr_if.slave bus
);
    localparam int unsigned ANCHO_CNT = 8;
    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(CICLOS_ACCESO - 1);
    localparam logic [ANCHO_POS-1:0] ULTIMO_RST = ANCHO_POS'(N_VENTANAS - 1);

    typedef enum logic [1:0] {
        LIBRE  = 2'd0,
        CAMBIO = 2'd1,
        ACCESO = 2'd2
    } estado_t;

    estado_t               estado, estado_sig;
    logic [ANCHO_POS-1:0]  posicion, posicion_sig;
    logic [ANCHO_POS-1:0]  ultimo, ultimo_sig;
    logic [ANCHO_CNT-1:0]  contador, contador_sig;
    logic                  habilitar_cambio, habilitar_sig;
    logic                  ocupado, ocupado_sig;
    logic [N_VENTANAS-1:0] concesion, concesion_sig;
    logic [ANCHO_POS-1:0]  ganador, gan_alto, gan_bajo;
    logic                  hay_alto, hay_bajo;

    // Round-robin pick: lowest requester above ultimo, else lowest at or below it
    always_comb begin
        gan_alto = '0;
        gan_bajo = '0;
        hay_alto = 1'b0;
        hay_bajo = 1'b0;
        for (int unsigned j = 0; j < N_VENTANAS; j++) begin
            if (bus.solicitud[j]) begin
                if (ANCHO_POS'(j) > ultimo) begin
                    if (!hay_alto) begin
                        gan_alto = ANCHO_POS'(j);
                        hay_alto = 1'b1;
                    end
                end else if (!hay_bajo) begin
                    gan_bajo = ANCHO_POS'(j);
                    hay_bajo = 1'b1;
                end
            end
        end
        ganador = hay_alto ? gan_alto : gan_bajo;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado           <= LIBRE;
            posicion         <= '0;
            ultimo           <= ULTIMO_RST;
            contador         <= '0;
            habilitar_cambio <= 1'b0;
            ocupado          <= 1'b0;
            concesion        <= '0;
        end else begin
            estado           <= estado_sig;
            posicion         <= posicion_sig;
            ultimo           <= ultimo_sig;
            contador         <= contador_sig;
            habilitar_cambio <= habilitar_sig;
            ocupado          <= ocupado_sig;
            concesion        <= concesion_sig;
        end
    end

    // Next state; posicion only reloads on the way into CAMBIO
    always_comb begin
        estado_sig   = estado;
        posicion_sig = posicion;
        ultimo_sig   = ultimo;
        contador_sig = contador;
        case (estado)
            LIBRE: begin
                if (|bus.solicitud) begin
                    posicion_sig = ganador;
                    estado_sig   = CAMBIO;
                end
            end
            CAMBIO: begin
                estado_sig   = ACCESO;
                contador_sig = '0;
                ultimo_sig   = posicion;
            end
            ACCESO: begin
                contador_sig = contador + ANCHO_CNT'(1);
                if ((contador == CNT_FIN) || !bus.solicitud[posicion]) begin
                    if (|bus.solicitud) begin
                        posicion_sig = ganador;
                        estado_sig   = CAMBIO;
                    end else begin
                        estado_sig = LIBRE;
                    end
                end
            end
            default: estado_sig = LIBRE;
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it
    always_comb begin
        habilitar_sig = (estado_sig == CAMBIO);
        ocupado_sig   = (estado_sig != LIBRE);
        concesion_sig = '0;
        if (estado_sig == ACCESO) begin
            concesion_sig = N_VENTANAS'(1) << posicion_sig;
        end
    end

    assign bus.posicion         = posicion;
    assign bus.habilitar_cambio = habilitar_cambio;
    assign bus.ocupado          = ocupado;
    assign bus.concesion        = concesion;
endmodule

// File: tb/tb_control_pos_memoria_rr.sv
// Bench for control_pos_memoria_rr: two instances (4-cycle and 1-cycle grants) share
// one request vector and are compared against a per-instance round-robin model.
module tb_control_pos_memoria_rr;
    localparam int N = 4;

    logic clk;
    logic reset;

    control_pos_memoria_rr_if #(.N_VENTANAS(N), .ANCHO_POS(2)) bus_a ();
    control_pos_memoria_rr_if #(.N_VENTANAS(N), .ANCHO_POS(2)) bus_b ();

    control_pos_memoria_rr #(.N_VENTANAS(N), .ANCHO_POS(2), .CICLOS_ACCESO(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    control_pos_memoria_rr #(.N_VENTANAS(N), .ANCHO_POS(2), .CICLOS_ACCESO(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 mux switch, 2 granted
    int m_fase[2];
    int m_duenio[2];
    int m_ultimo[2];
    int m_usados[2];
    int m_lim[2];

    function automatic int rr(input logic [3:0] req, input int ult);
        for (int k = 1; k <= N; k++) begin
            if (req[(ult + k) % N]) return (ult + k) % N;
        end
        return ult;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fase[i]   = 0;
            m_duenio[i] = 0;
            m_ultimo[i] = N - 1;
            m_usados[i] = 0;
        end
        m_lim[0] = 4;
        m_lim[1] = 1;
    endtask

    task automatic model_edge(input logic [3:0] req);
        for (int i = 0; i < 2; i++) begin
            if (m_fase[i] == 0) begin
                if (req != 0) begin
                    m_duenio[i] = rr(req, m_ultimo[i]);
                    m_fase[i]   = 1;
                end
            end else if (m_fase[i] == 1) begin
                m_fase[i]   = 2;
                m_ultimo[i] = m_duenio[i];
                m_usados[i] = 0;
            end else begin
                m_usados[i]++;
                if (m_usados[i] == m_lim[i] || !req[m_duenio[i]]) begin
                    if (req != 0) begin
                        m_duenio[i] = rr(req, m_ultimo[i]);
                        m_fase[i]   = 1;
                    end else begin
                        m_fase[i] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_conc(input int i);
        return (m_fase[i] == 2) ? (32'd1 << m_duenio[i]) : 32'd0;
    endfunction

    task automatic compare_all(input string ctx);
        check({ctx, ".a.pos"}, 32'(bus_a.posicion), 32'(m_duenio[0]));
        check({ctx, ".a.hab"}, 32'(bus_a.habilitar_cambio), 32'(m_fase[0] == 1));
        check({ctx, ".a.conc"}, 32'(bus_a.concesion), exp_conc(0));
        check({ctx, ".a.ocup"}, 32'(bus_a.ocupado), 32'(m_fase[0] != 0));
        check({ctx, ".b.pos"}, 32'(bus_b.posicion), 32'(m_duenio[1]));
        check({ctx, ".b.hab"}, 32'(bus_b.habilitar_cambio), 32'(m_fase[1] == 1));
        check({ctx, ".b.conc"}, 32'(bus_b.concesion), exp_conc(1));
        check({ctx, ".b.ocup"}, 32'(bus_b.ocupado), 32'(m_fase[1] != 0));
    endtask

    task automatic check_cleared(input string ctx);
        check({ctx, ".a.pos"}, 32'(bus_a.posicion), 32'd0);
        check({ctx, ".a.hab"}, 32'(bus_a.habilitar_cambio), 32'd0);
        check({ctx, ".a.conc"}, 32'(bus_a.concesion), 32'd0);
        check({ctx, ".a.ocup"}, 32'(bus_a.ocupado), 32'd0);
        check({ctx, ".b.conc"}, 32'(bus_b.concesion), 32'd0);
        check({ctx, ".b.ocup"}, 32'(bus_b.ocupado), 32'd0);
    endtask

    // One clock: drive request, let the edge happen, then compare just after it
    task automatic step(input logic [3:0] req, input string ctx);
        bus_a.solicitud = req;
        bus_b.solicitud = req;
        @(posedge clk);
        model_edge(req);
        #1;
        compare_all(ctx);
    endtask

    // Asynchronous reset pulse raised between edges; outputs must clear before the next edge
    task automatic pulse_reset(input string ctx);
        #3;
        reset = 1'b1;
        #1;
        check_cleared(ctx);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int         hab_pos[$];
    int         hab_t[$];
    logic [3:0] req_r;
    bit         reached;

    initial begin
        reset = 1'b0;
        bus_a.solicitud = '0;
        bus_b.solicitud = '0;
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        check_cleared("rst0");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester 2, released before the grant window expires
        for (int k = 1; k <= 5; k++) begin
            step(4'b0100, "r29");
            if (k == 1) begin
                check("r29.pos2", 32'(bus_a.posicion), 32'd2);
                check("r29.hab", 32'(bus_a.habilitar_cambio), 32'd1);
            end else begin
                check("r29.conc", 32'(bus_a.concesion), 32'h4);
            end
        end
        step(4'b0000, "r29");
        check("r29.libre", 32'(bus_a.ocupado), 32'd0);

        // All requesting: strict rotation starting at window 0, period 1+4
        pulse_reset("r30rst");
        for (int k = 0; k < 26; k++) begin
            step(4'b1111, "r30");
            if (bus_a.habilitar_cambio) begin
                hab_pos.push_back(int'(bus_a.posicion));
                hab_t.push_back(k);
            end
        end
        check("r30.npulses", 32'(hab_pos.size()), 32'd6);
        for (int k = 0; k < 5 && k < hab_pos.size(); k++) begin
            check("r30.seq", 32'(hab_pos[k]), 32'(k % 4));
            if (k > 0) check("r30.period", 32'(hab_t[k] - hab_t[k-1]), 32'd5);
        end

        // Owner 1 releases in its second grant cycle with window 3 pending
        pulse_reset("r31rst");
        step(4'b0010, "r31");
        step(4'b1010, "r31");
        step(4'b1010, "r31");
        step(4'b1000, "r31");
        check("r31.pos3", 32'(bus_a.posicion), 32'd3);
        check("r31.hab", 32'(bus_a.habilitar_cambio), 32'd1);
        check("r31.conc0", 32'(bus_a.concesion), 32'd0);

        // Reset during window 2's grant restarts arbitration at window 0
        pulse_reset("r32rst");
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            step(4'b1111, "r32");
            if (m_fase[0] == 2 && m_duenio[0] == 2) reached = 1'b1;
        end
        check("r32.reach", 32'(reached), 32'd1);
        pulse_reset("r32mid");
        step(4'b1111, "r32");
        check("r32.pos0", 32'(bus_a.posicion), 32'd0);
        check("r32.hab", 32'(bus_a.habilitar_cambio), 32'd1);

        // Single-cycle grants with two requesters alternate every two cycles
        pulse_reset("r33rst");
        for (int k = 1; k <= 8; k++) begin
            step(4'b0011, "r33");
            if (k % 2 == 1) check("r33.hab", 32'(bus_b.habilitar_cambio), 32'd1);
            else check("r33.conc", 32'(bus_b.concesion), ((k / 2) % 2 == 1) ? 32'h1 : 32'h2);
        end

        // Random sticky requests with occasional reset pulses
        req_r = 4'($urandom);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3, 0) == 0) req_r = 4'($urandom);
            if ($urandom_range(199, 0) == 0) pulse_reset("rnd.rst");
            step(req_r, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
